// File: rtl/output_accum_classifier.sv
// rtl/output_accum_classifier.sv - per-class popcount, EMA accumulate and argmax of a logic-gate network output
// Define OUTPUT_ACCUM_MOVING_AVERAGE_EN for EMA smoothing; otherwise each sample is classified on its own counts.
module output_accum_classifier #(
    parameter int NET_WIDTH                  = 8000,
    parameter int NUM_CLASSES                = 10,
    parameter int NET_TO_OUT_DELAY           = 2,
    parameter int MOVING_AVERAGE_DIV         = 4,
    parameter int MOVING_AVERAGE_ACCUM_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [NET_WIDTH-1:0]   net_i,
    input  logic                   inp_valid_i,
    output logic [NUM_CLASSES-1:0] class_out_o,
    output logic                   out_valid_o
);
    localparam int G  = NET_WIDTH / NUM_CLASSES;
    localparam int CW = $clog2(G + 1);
    localparam int G0 = G / 2;
    localparam int W  = MOVING_AVERAGE_ACCUM_WIDTH;
    localparam int W1 = W + 1;
    localparam int D  = NET_TO_OUT_DELAY;
    localparam int DP = (D > 1) ? D - 1 : 1;

    logic [NET_WIDTH-1:0]                    net_q, net_d;
    logic                                    in_valid_q, in_valid_d;
    logic [NUM_CLASSES-1:0][CW-1:0]          part0_q, part0_d, part1_q, part1_d;
    logic [DP-1:0][NUM_CLASSES-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [D-1:0]                            vld_q, vld_d;
    logic [NUM_CLASSES-1:0][W-1:0]           acc_q, acc_d;
    logic                                    acc_valid_q, acc_valid_d;
    logic [NUM_CLASSES-1:0]                  class_q, class_d;
    logic                                    out_valid_q, out_valid_d;
    logic [NUM_CLASSES-1:0][CW-1:0]          count;

    // Stage 1 popcounts each group as two halves; stage 2 joins them; later stages only delay.
    always_comb begin
        net_d      = inp_valid_i ? net_i : net_q;
        in_valid_d = inp_valid_i;
        part0_d    = '0;
        part1_d    = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int i = 0; i < G; i++) begin
                if (i < G0) part0_d[c] = part0_d[c] + CW'(net_q[c*G + i]);
                else        part1_d[c] = part1_d[c] + CW'(net_q[c*G + i]);
            end
        end
        cnt_d = cnt_q;
        for (int c = 0; c < NUM_CLASSES; c++) cnt_d[0][c] = part0_q[c] + part1_q[c];
        for (int s = 1; s < DP; s++) cnt_d[s] = cnt_q[s-1];
        vld_d    = vld_q;
        vld_d[0] = in_valid_q;
        for (int s = 1; s < D; s++) vld_d[s] = vld_q[s-1];
    end

    generate
        if (D == 1) begin : g_cnt_direct
            always_comb begin
                count = '0;
                for (int c = 0; c < NUM_CLASSES; c++) count[c] = part0_q[c] + part1_q[c];
            end
        end else begin : g_cnt_piped
            assign count = cnt_q[DP-1];
        end
    endgenerate

    always_comb begin
        acc_d       = acc_q;
        acc_valid_d = vld_q[D-1];
        if (vld_q[D-1]) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
`ifdef OUTPUT_ACCUM_MOVING_AVERAGE_EN
                logic [W1-1:0] sum;
                // Width W+1 cannot overflow: acc - (acc>>k) <= acc, and count <= 2^W-1.
                sum = {1'b0, acc_q[c]} - ({1'b0, acc_q[c]} >> MOVING_AVERAGE_DIV) + W1'(count[c]);
                acc_d[c] = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
                acc_d[c] = W'(count[c]);
`endif
            end
        end
    end

`ifndef OUTPUT_ACCUM_MOVING_AVERAGE_EN
    localparam int ema_div_unused = MOVING_AVERAGE_DIV;
`endif

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        logic [W-1:0] best_val;
        int           best_idx;
        best_val = acc_q[0];
        best_idx = 0;
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc_q[c] > best_val) begin
                best_val = acc_q[c];
                best_idx = c;
            end
        end
        class_d = class_q;
        if (acc_valid_q) begin
            class_d           = '0;
            class_d[best_idx] = 1'b1;
        end
        out_valid_d = acc_valid_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            net_q       <= '0;
            in_valid_q  <= 1'b0;
            part0_q     <= '0;
            part1_q     <= '0;
            cnt_q       <= '0;
            vld_q       <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            class_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            net_q       <= net_d;
            in_valid_q  <= in_valid_d;
            part0_q     <= part0_d;
            part1_q     <= part1_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            class_q     <= class_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign class_out_o = class_q;
    assign out_valid_o = out_valid_q;
endmodule

// File: tb/tb_output_accum_classifier.sv
// tb/tb_output_accum_classifier.sv - directed self-checking bench for output_accum_classifier
module tb_output_accum_classifier;
    localparam int NW = 8000;
    localparam int NC = 10;
    localparam int G  = 800;
`ifdef OUTPUT_ACCUM_MOVING_AVERAGE_EN
    localparam bit EMA = 1'b1;
`else
    localparam bit EMA = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_ni;
    logic [NW-1:0] net;
    logic          vin;
    logic [NC-1:0] cls, cls_s;
    logic          ov, ov_s;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    output_accum_classifier #(.NET_WIDTH(NW), .NUM_CLASSES(NC), .NET_TO_OUT_DELAY(2),
        .MOVING_AVERAGE_DIV(4), .MOVING_AVERAGE_ACCUM_WIDTH(16)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .net_i(net), .inp_valid_i(vin),
        .class_out_o(cls), .out_valid_o(ov));

    output_accum_classifier #(.NET_WIDTH(NW), .NUM_CLASSES(NC), .NET_TO_OUT_DELAY(2),
        .MOVING_AVERAGE_DIV(4), .MOVING_AVERAGE_ACCUM_WIDTH(10)) dut_s (
        .clk_i(clk), .reset_ni(reset_ni), .net_i(net), .inp_valid_i(vin),
        .class_out_o(cls_s), .out_valid_o(ov_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [NW-1:0] grp(input int c);
        logic [NW-1:0] v;
        v = '0;
        v[c*G +: G] = '1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0; vin = 1'b0; net = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {cls, ov}, 0);
        reset_ni = 1'b1;
    endtask

    task automatic run_sample(input logic [NW-1:0] v, input string tag,
                              input logic [31:0] exp_cls, input int acc_idx, input logic [31:0] exp_acc);
        int early;
        early = 0;
        @(negedge clk); net = v; vin = 1'b1;
        @(negedge clk); net = '0; vin = 1'b0; early += int'(ov);
        repeat (3) begin @(negedge clk); early += int'(ov); end
        @(negedge clk);
        chk({tag, "_early"}, early, 0);
        chk({tag, "_valid"}, ov, 1);
        chk({tag, "_class"}, cls, exp_cls);
        chk({tag, "_acc"}, dut.acc_q[acc_idx], exp_acc);
        @(negedge clk);
        chk({tag, "_pulse_end"}, ov, 0);
    endtask

    initial begin
        int dec_acc[5] = '{750, 704, 660, 619, 581};
        int pulses;
        reset_ni = 1'b0; vin = 1'b0; net = '0;

        // Reset held while inputs toggle randomly
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int w = 0; w < NW/32; w++) net[w*32 +: 32] = $urandom;
            vin = 1'($urandom_range(0, 1));
            chk("reset_hold", {cls, ov}, 0);
        end
        @(negedge clk); vin = 1'b0; net = '0;
        chk("reset_hold_last", {cls, ov}, 0);
        reset_ni = 1'b1;
        repeat (3) begin @(negedge clk); chk("post_reset_idle", {cls, ov}, 0); end

        run_sample(grp(3), "single_c3", 32'h008, 3, 800);
        for (int k = 0; k < 5; k++)
            run_sample('0, $sformatf("decay%0d", k), EMA ? 32'h008 : 32'h001, 3, EMA ? dec_acc[k] : 0);

        do_reset();
        run_sample('1, "tie_ones", 32'h001, 9, 800);
        do_reset();
        run_sample('0, "tie_zero", 32'h001, 0, 0);

        // Back-to-back samples: classes 2, 7, 7
        do_reset();
        @(negedge clk); net = grp(2); vin = 1'b1;
        @(negedge clk); net = grp(7);
        @(negedge clk); net = grp(7);
        @(negedge clk); net = '0; vin = 1'b0;
        chk("b2b_early0", ov, 0);
        @(negedge clk); chk("b2b_early1", ov, 0);
        @(negedge clk); chk("b2b_v0", ov, 1); chk("b2b_c0", cls, 32'h004);
        @(negedge clk); chk("b2b_v1", ov, 1); chk("b2b_c1", cls, 32'h080);
        @(negedge clk); chk("b2b_v2", ov, 1); chk("b2b_c2", cls, 32'h080);
        chk("b2b_acc7", dut.acc_q[7], EMA ? 1550 : 800);
        @(negedge clk); chk("b2b_end", ov, 0); chk("b2b_hold", cls, 32'h080);

        // Saturation on the 10-bit instance
        do_reset();
        run_sample(grp(0), "sat1", 32'h001, 0, 800);
        chk("sat1_w10_acc", dut_s.acc_q[0], 800);
        run_sample(grp(0), "sat2", 32'h001, 0, EMA ? 1550 : 800);
        chk("sat2_w10_acc", dut_s.acc_q[0], EMA ? 1023 : 800);
        chk("sat2_w10_class", cls_s, 32'h001);

        do_reset();
        run_sample(grp(5), "c5", 32'h020, 5, 800);
        run_sample(grp(1), "c1", 32'h002, 1, 800);

        // Reset two cycles after a valid discards the in-flight sample
        do_reset();
        @(negedge clk); net = grp(4); vin = 1'b1;
        @(negedge clk); net = '0; vin = 1'b0;
        @(negedge clk); reset_ni = 1'b0;
        @(negedge clk); reset_ni = 1'b1;
        pulses = 0;
        repeat (8) begin @(negedge clk); pulses += int'(ov); end
        chk("midflight_pulses", pulses, 0);
        chk("midflight_class", cls, 0);
        chk("midflight_acc4", dut.acc_q[4], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
